func_tt_checker: RTL

Response-side companion to the exhaustive 4-input stimulus sweep of the combinational minimisation designs. It drives a,b,c,d through all 16 vectors in ascending order with a = MSB, holding each vector for DWELL cycles. On the last dwell cycle it samples the function output z_in, builds a 16-bit captured truth table, compares it against an expected minterm mask, and reports pass/fail plus error details. It sits between a control/test harness and the combinational function under check.

---
 rtl/func_tt_checker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/func_tt_checker.sv
// Response-side truth-table checker: sweeps {a,b,c,d} through 0..15, samples z_in after
// DWELL cycles per vector and compares the captured table against a latched expected mask.
module func_tt_checker #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        z_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_err_idx,
  output logic        err_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [7:0]  dwell_r, dwell_s;
  logic [15:0] exp_r, exp_s;
  logic [3:0]  vec_r, vec_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        pass_r, pass_s;
  logic [15:0] cap_r, cap_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [3:0]  ferr_r, ferr_s;
  logic        errv_r, errv_s;
  logic        miss_s;

  // Next-state and next-register computation for the sweep FSM
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    dwell_s = dwell_r;
    exp_s   = exp_r;
    vec_s   = vec_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    pass_s  = pass_r;
    cap_s   = cap_r;
    cnt_s   = cnt_r;
    ferr_s  = ferr_r;
    errv_s  = errv_r;
    miss_s  = z_in ^ exp_r[idx_r];
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
          exp_s   = expected;
          cap_s   = 16'h0000;
          cnt_s   = 5'd0;
          ferr_s  = 4'd0;
          errv_s  = 1'b0;
          pass_s  = 1'b0;
          idx_s   = 4'd0;
          dwell_s = 8'd0;
          vec_s   = 4'd0;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (dwell_r != DWELL_LAST) begin
          dwell_s = dwell_r + 8'd1;
        end else begin
          cap_s[idx_r] = z_in;
          dwell_s      = 8'd0;
          if (miss_s) begin
            cnt_s = cnt_r + 5'd1;
            // Only the lowest failing index is recorded; vectors arrive in ascending order
            if (!errv_r) begin
              ferr_s = idx_r;
              errv_s = 1'b1;
            end else begin
              ferr_s = ferr_r;
            end
          end else begin
            cnt_s = cnt_r;
          end
          if (idx_r != 4'd15) begin
            idx_s = idx_r + 4'd1;
            vec_s = idx_r + 4'd1;
          end else begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (cap_s == exp_r);
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        vec_s   = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        vec_s   = 4'd0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
      dwell_r <= 8'd0;
      exp_r   <= 16'h0000;
      vec_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      cap_r   <= 16'h0000;
      cnt_r   <= 5'd0;
      ferr_r  <= 4'd0;
      errv_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      dwell_r <= dwell_s;
      exp_r   <= exp_s;
      vec_r   <= vec_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      cap_r   <= cap_s;
      cnt_r   <= cnt_s;
      ferr_r  <= ferr_s;
      errv_r  <= errv_s;
    end
  end

  assign a             = vec_r[3];
  assign b             = vec_r[2];
  assign c             = vec_r[1];
  assign d             = vec_r[0];
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign captured      = cap_r;
  assign mismatch_cnt  = cnt_r;
  assign first_err_idx = ferr_r;
  assign err_valid     = errv_r;

endmodule
